// File: rtl/fft_demux.sv
// Registered three-way stage distributor: routes each accepted word to one of
// three output registers by a wrapping phase counter. Optional FFT_DEMUX_ERR_EN adds a sticky dropped-word flag.
module fft_demux #(
  parameter int DATA_W   = 136,
  parameter int SEG1_END = 4,
  parameter int SEG2_END = 8,
  parameter int PERIOD   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              demux_flag,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic              out_valid_3,
  output logic [3:0]        phase,
  output logic              frame_done,
  output logic              err
);

  localparam logic [3:0] SEG1_L = 4'(SEG1_END);
  localparam logic [3:0] SEG2_L = 4'(SEG2_END);
  localparam logic [3:0] LAST_L = 4'(PERIOD - 1);

  logic       acc_s;
  logic [3:0] p_s;
  logic [3:0] next_phase_s;
  logic       wrap_s;
  logic [1:0] sel_s;
  logic [3:0] phase_r;

  assign phase = phase_r;

  // Effective phase (clr restarts the frame), port select and next phase
  always_comb begin
    acc_s = in_valid & demux_flag;
    if (clr) begin
      p_s = 4'd0;
    end else begin
      p_s = phase_r;
    end
    if (p_s < SEG1_L) begin
      sel_s = 2'd1;
    end else if (p_s < SEG2_L) begin
      sel_s = 2'd2;
    end else begin
      sel_s = 2'd3;
    end
    wrap_s = (p_s == LAST_L);
    if (wrap_s) begin
      next_phase_s = 4'd0;
    end else begin
      next_phase_s = p_s + 4'd1;
    end
  end

  // Phase counter, per-port data registers and one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r     <= 4'd0;
      data_out_1  <= {DATA_W{1'b0}};
      data_out_2  <= {DATA_W{1'b0}};
      data_out_3  <= {DATA_W{1'b0}};
      out_valid_1 <= 1'b0;
      out_valid_2 <= 1'b0;
      out_valid_3 <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      out_valid_1 <= 1'b0;
      out_valid_2 <= 1'b0;
      out_valid_3 <= 1'b0;
      frame_done  <= 1'b0;
      if (acc_s) begin
        phase_r    <= next_phase_s;
        frame_done <= wrap_s;
        case (sel_s)
          2'd1: begin
            data_out_1  <= data_in;
            out_valid_1 <= 1'b1;
          end
          2'd2: begin
            data_out_2  <= data_in;
            out_valid_2 <= 1'b1;
          end
          2'd3: begin
            data_out_3  <= data_in;
            out_valid_3 <= 1'b1;
          end
          default: begin
            data_out_1 <= data_out_1;
          end
        endcase
      end else if (clr) begin
        phase_r <= 4'd0;
      end else begin
        phase_r <= phase_r;
      end
    end
  end

`ifdef FFT_DEMUX_ERR_EN
  logic err_r;
  assign err = err_r;

  // Sticky drop flag: a valid word offered while the demux is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (clr) begin
      err_r <= 1'b0;
    end else if (in_valid && !demux_flag) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_demux.sv
// Self-checking bench for fft_demux: randomized words checked against a
// frame/segment reference model, plus a small-period instance for routing order.
module tb_fft_demux;

  localparam int DW  = 136;
  localparam int S1  = 4;
  localparam int S2  = 8;
  localparam int PER = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          demux_flag = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out_1, data_out_2, data_out_3;
  logic          out_valid_1, out_valid_2, out_valid_3;
  logic [3:0]    phase;
  logic          frame_done, err;

  logic          s_flag = 1'b0;
  logic          s_clr = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] s_out_1, s_out_2, s_out_3;
  logic          s_ov_1, s_ov_2, s_ov_3;
  logic [3:0]    s_phase;
  logic          s_fd, s_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] exp_d [1:3];
  logic [2:0]    exp_v;
  int            exp_ph;
  logic          exp_fd;
  logic          exp_err;

  always #5 clk = ~clk;

  fft_demux dut (
    .clk(clk), .rst(rst), .demux_flag(demux_flag), .clr(clr),
    .in_valid(in_valid), .data_in(data_in),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2), .out_valid_3(out_valid_3),
    .phase(phase), .frame_done(frame_done), .err(err)
  );

  fft_demux #(.DATA_W(DW), .SEG1_END(1), .SEG2_END(2), .PERIOD(3)) dut_small (
    .clk(clk), .rst(rst), .demux_flag(s_flag), .clr(s_clr),
    .in_valid(s_valid), .data_in(s_data),
    .data_out_1(s_out_1), .data_out_2(s_out_2), .data_out_3(s_out_3),
    .out_valid_1(s_ov_1), .out_valid_2(s_ov_2), .out_valid_3(s_ov_3),
    .phase(s_phase), .frame_done(s_fd), .err(s_err)
  );

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  function automatic int port_of(input int p, input int s1, input int s2);
    if (p < s1) return 1;
    else if (p < s2) return 2;
    else return 3;
  endfunction

  function automatic logic [3*DW+6:0] obs_pack();
    return {data_out_1, data_out_2, data_out_3,
            out_valid_3, out_valid_2, out_valid_1, phase, frame_done, err};
  endfunction

  function automatic logic [3*DW+6:0] exp_pack();
    logic [3:0] ph;
    ph = 4'(exp_ph);
    return {exp_d[1], exp_d[2], exp_d[3], exp_v, ph, exp_fd, exp_err};
  endfunction

  task automatic model_reset();
    exp_d[1] = '0; exp_d[2] = '0; exp_d[3] = '0;
    exp_v = 3'b000; exp_ph = 0; exp_fd = 1'b0; exp_err = 1'b0;
  endtask

  // What the spec says one clock edge does, given the inputs seen at that edge
  task automatic model_edge(input logic v, input logic f, input logic c, input logic [DW-1:0] d);
    int p;
    int k;
    exp_v = 3'b000;
    exp_fd = 1'b0;
    p = c ? 0 : exp_ph;
    if (v && f) begin
      k = port_of(p, S1, S2);
      exp_d[k] = d;
      exp_v[k-1] = 1'b1;
      exp_ph = (p + 1) % PER;
      exp_fd = (p == PER - 1);
    end else if (c) begin
      exp_ph = 0;
    end
`ifdef FFT_DEMUX_ERR_EN
    if (c) exp_err = 1'b0;
    else if (v && !f) exp_err = 1'b1;
`endif
  endtask

  task automatic step(input logic v, input logic f, input logic c, input logic [DW-1:0] d);
    in_valid = v; demux_flag = f; clr = c; data_in = d;
    @(posedge clk);
    #1;
    model_edge(v, f, c, d);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs_pack(), exp_pack());
    end
  endtask

  task automatic test_frame();
    logic [DW-1:0] w;
    for (int i = 0; i < 12; i++) begin
      w = DW'(i + 1);
      step(1'b1, 1'b1, 1'b0, w);
      checks++;
      if (obs_pack() !== exp_pack()) begin
        errors++;
        $display("FAIL frame_word%0d got=%h want=%h", i + 1, obs_pack(), exp_pack());
      end
    end
    checks++;
    if (frame_done !== 1'b1 || phase !== 4'd0 || data_out_3 !== DW'(12)) begin
      errors++;
      $display("FAIL frame_end got fd=%b ph=%0d d3=%h want fd=1 ph=0 d3=c", frame_done, phase, data_out_3);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, rand_word());
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", obs_pack(), exp_pack());
    end
    #2 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, DW'(8'hAA));
    checks++;
    if (out_valid_1 !== 1'b1 || data_out_1 !== DW'(8'hAA) || phase !== 4'd1 || obs_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL post_reset_accept got v1=%b d1=%h ph=%0d want v1=1 d1=aa ph=1", out_valid_1, data_out_1, phase);
    end
  endtask

  task automatic test_clr();
    logic [DW-1:0] w6;
    step(1'b0, 1'b1, 1'b1, rand_word());
    checks++;
    if (obs_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL clr_only got=%h want=%h", obs_pack(), exp_pack());
    end
    w6 = '0;
    for (int i = 0; i < 6; i++) begin
      w6 = rand_word();
      step(1'b1, 1'b1, 1'b0, w6);
    end
    step(1'b1, 1'b1, 1'b1, DW'(8'h55));
    checks++;
    if (data_out_1 !== DW'(8'h55) || out_valid_1 !== 1'b1 || phase !== 4'd1 || data_out_2 !== w6) begin
      errors++;
      $display("FAIL clr_with_word got d1=%h ph=%0d d2=%h want d1=55 ph=1 d2=%h", data_out_1, phase, data_out_2, w6);
    end
    checks++;
    if (obs_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL clr_with_word_model got=%h want=%h", obs_pack(), exp_pack());
    end
  endtask

  task automatic test_flag_low();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, rand_word());
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, rand_word());
      checks++;
      if (obs_pack() !== exp_pack() || phase !== 4'd4) begin
        errors++;
        $display("FAIL flag_low%0d got=%h want=%h", i, obs_pack(), exp_pack());
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, rand_word());
      checks++;
`ifdef FFT_DEMUX_ERR_EN
      if (err !== 1'b1 || obs_pack() !== exp_pack()) begin
`else
      if (err !== 1'b0 || obs_pack() !== exp_pack()) begin
`endif
        errors++;
        $display("FAIL err_sticky got err=%b obs=%h want=%h", err, obs_pack(), exp_pack());
      end
    end
    step(1'b1, 1'b0, 1'b1, rand_word());
    checks++;
    if (err !== 1'b0 || obs_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL err_clr got err=%b obs=%h want=%h", err, obs_pack(), exp_pack());
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt;
    int fd_at [$];
    step(1'b0, 1'b1, 1'b1, '0);
    fd_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 1'b1, 1'b0, rand_word());
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_at.push_back(i);
      end
      checks++;
      if (obs_pack() !== exp_pack() || $countones({out_valid_1, out_valid_2, out_valid_3}) != 1) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", i, obs_pack(), exp_pack());
      end
    end
    checks++;
    if (fd_cnt != 3 || fd_at.size() != 3 || fd_at[0] != 11 || fd_at[1] != 23 || fd_at[2] != 35) begin
      errors++;
      $display("FAIL b2b_frame_done got count=%0d want 3 at cycles 11,23,35", fd_cnt);
    end
  endtask

  task automatic test_random();
    logic v, f, c;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 15) == 0);
      step(v, f, c, rand_word());
      checks++;
      if (obs_pack() !== exp_pack()) begin
        errors++;
        $display("FAIL random%0d got=%h want=%h", i, obs_pack(), exp_pack());
      end
    end
  endtask

  task automatic test_small_period();
    logic [2:0]    want_v;
    logic [DW-1:0] w;
    logic [DW-1:0] got_d;
    int            k;
    for (int i = 0; i < 6; i++) begin
      w = rand_word();
      s_valid = 1'b1; s_flag = 1'b1; s_clr = 1'b0; s_data = w;
      @(posedge clk);
      #1;
      k = (i % 3) + 1;
      want_v = 3'b000;
      want_v[k-1] = 1'b1;
      got_d = (k == 1) ? s_out_1 : (k == 2) ? s_out_2 : s_out_3;
      checks++;
      if ({s_ov_3, s_ov_2, s_ov_1} !== want_v || got_d !== w || s_fd !== (k == 3)) begin
        errors++;
        $display("FAIL small_order%0d got strobes=%b fd=%b want strobes=%b fd=%b", i, {s_ov_3, s_ov_2, s_ov_1}, s_fd, want_v, (k == 3));
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_async_reset();
    test_clr();
    test_flag_low();
    test_back_to_back();
    test_random();
    test_small_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_demux.md
# fft_demux

Registered three-way stage distributor for the FFT datapath, the write-side counterpart of the stage selector that merges three 136-bit streams into one. It accepts one 136-bit word per qualified cycle and routes it to one of three output registers. Routing follows an internal 4-bit phase counter that advances per accepted word and wraps once per frame. A per-port valid strobe marks each update, and a frame-done pulse marks the end of each frame.

## Interface
- DATA_W, 136, word width (8 lanes x 17 bits)
- SEG1_END, 4, first phase routed to port 2
- SEG2_END, 8, first phase routed to port 3
- PERIOD, 12, phases per frame; legal range 0 < SEG1_END < SEG2_END < PERIOD <= 16
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- demux_flag  input  1  enable; words are accepted only while high
- clr  input  1  synchronous frame restart
- in_valid  input  1  data_in carries a word this cycle
- data_in  input  DATA_W  input word
- data_out_1 / data_out_2 / data_out_3  output  DATA_W  per-port registered word, held between updates
- out_valid_1 / out_valid_2 / out_valid_3  output  1  one-cycle strobe marking a port update
- phase  output  4  current phase counter value
- frame_done  output  1  one-cycle pulse after the last word of a frame
- err  output  1  sticky dropped-word flag (see Configuration)

## Operation
- Accept condition: acc = in_valid & demux_flag.
- Routing by effective phase p:
  - p < SEG1_END: port 1
  - SEG1_END <= p < SEG2_END: port 2
  - otherwise: port 3
- Effective phase p is 0 when clr is high, otherwise phase.
- On acc:
  - The selected port register loads data_in and its out_valid pulses. The other ports keep their values and their strobes stay low.
  - The next phase is p+1, or 0 when p == PERIOD-1, in which case frame_done pulses.
- clr without acc: phase goes to 0. No strobes. Data registers are untouched.
- clr with acc: clr takes priority for phase. The word is routed as phase 0 and phase becomes 1, or 0 if PERIOD == 1 (illegal by the constraint above).
- demux_flag low: phase frozen, no strobes, data registers hold.
- Phase never exceeds PERIOD-1. Values from PERIOD to 15 are unreachable.
- Reset (asynchronous, at any time, including mid-frame):
  - phase, all data_out, all out_valid, frame_done and err go to 0 immediately.
  - The first word accepted after release is phase 0.

## Timing
- Latency is 1 cycle. A word accepted at edge N is visible on data_out_k, with out_valid_k high, from edge N until edge N+1.
- out_valid_k and frame_done are high for exactly one cycle per event. Back-to-back accepts give back-to-back strobes, possibly on different ports.
- phase reflects all accepts up to and including the last edge.
- frame_done is asserted in the same cycle as the strobe for phase PERIOD-1.
- No backpressure; every acc is consumed.
- Throughput is one word per clock.

## Configuration
- FFT_DEMUX_ERR_EN
  - Defined: err sets on any cycle with in_valid high and demux_flag low (dropped word). err is sticky and clears only on rst or clr. If clr and a drop occur in the same cycle, clr wins and err = 0.
  - Undefined: err is tied to 0 and no related logic is built.

## Test plan
- Reset then 12 accepts of data 0x1..0xC with defaults:
  - Port 1 strobes with 0x1..0x4, port 2 with 0x5..0x8, port 3 with 0x9..0xC.
  - frame_done goes high with the 0xC strobe; phase returns to 0.
- Accept 5 words, then assert rst asynchronously mid-cycle:
  - All outputs go to 0 before the next edge.
  - The next accept, 0xAA, strobes port 1 and phase becomes 1.
- Accept 6 words, then apply clr together with valid word 0x55:
  - 0x55 goes to port 1 and phase becomes 1.
  - data_out_2 still holds word 6.
- Toggle demux_flag low for 3 valid cycles mid-frame:
  - Phase frozen, no strobes.
  - With FFT_DEMUX_ERR_EN, err = 1 and stays set until clr.
  - Without it, err stays 0.
- Continuous valid for 36 cycles: exactly 3 frame_done pulses, spaced 12 cycles apart, and no gaps in the strobes.
- Override to SEG1_END=1, SEG2_END=2, PERIOD=3 and send 6 words: ports strobe in the order 1,2,3,1,2,3.
